hazard_scoreboard: RTL

- Hazard and forwarding controller for the 5-stage MIPS pipeline. Sits between D-stage decode and the E-stage datapath, including the E-stage multiply/divide unit.
- Keeps a registered shadow of the destination register and remaining result latency (Tnew) for the E, M and W stages. From this it decides D-stage stalls and produces forwarding selects for the D and E stages.
- Also consumes the multiply/divide busy signal, so HI/LO-related instructions hold in D while that unit is occupied.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
// hazard_scoreboard
//   Hazard and forwarding controller for the 5-stage MIPS pipeline.
//   Keeps a registered shadow of destination register and remaining result
//   latency (Tnew) for the E, M and W stages. From it, the block derives the
//   D-stage stall and the D/E-stage forwarding selects. It also holds
//   HI/LO-related instructions in D while the multiply/divide unit is busy.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   d_rs, d_rt            D-stage source register numbers
//   d_use_rs, d_use_rt    D instruction actually reads rs / rt
//   d_tuse_rs, d_tuse_rt  cycles until the operand is needed (0=D, 1=E, 2=M)
//   d_dst, d_tnew         D destination (0 = none) and result latency from E
//   d_is_md               D instruction uses the mult/div unit or HI/LO
//   e_md_stall            mult/div unit busy
//   stall                 freeze PC and F/D, inject bubble into E
//   d_fwd_rs, d_fwd_rt    D operand select: 0 regfile, 1 E, 2 M, 3 W
//   e_fwd_rs, e_fwd_rt    E operand select: 0 held operand, 2 M, 3 W
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic [ADDR_W-1:0] d_dst,
    input  logic [T_W-1:0]    d_tnew,
    input  logic              d_is_md,
    input  logic              e_md_stall,
    output logic              stall,
    output logic [1:0]        d_fwd_rs,
    output logic [1:0]        d_fwd_rt,
    output logic [1:0]        e_fwd_rs,
    output logic [1:0]        e_fwd_rt
);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_E    = 2'd1;
    localparam logic [1:0] SEL_M    = 2'd2;
    localparam logic [1:0] SEL_W    = 2'd3;

    // E slot keeps its source numbers for E-stage forwarding; M and W only
    // need destination info. W forwards unconditionally, so its remaining
    // latency is not tracked.
    logic [ADDR_W-1:0] r_e_rs;
    logic [ADDR_W-1:0] r_e_rt;
    logic [ADDR_W-1:0] r_e_dst;
    logic [T_W-1:0]    r_e_tnew;
    logic [ADDR_W-1:0] r_m_dst;
    logic [T_W-1:0]    r_m_tnew;
    logic [ADDR_W-1:0] r_w_dst;

    logic w_rs_stall;
    logic w_rt_stall;
    logic w_md_stall;

    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // $0 is hard-wired zero, so it never matches a producer.
    function automatic logic hit(input logic [ADDR_W-1:0] dst,
                                 input logic [ADDR_W-1:0] r);
        return (r != '0) && (dst == r);
    endfunction

    function automatic logic data_stall(input logic [ADDR_W-1:0] r,
                                        input logic              use_r,
                                        input logic [T_W-1:0]    tuse,
                                        input logic [ADDR_W-1:0] e_dst,
                                        input logic [T_W-1:0]    e_tnew,
                                        input logic [ADDR_W-1:0] m_dst,
                                        input logic [T_W-1:0]    m_tnew);
        return use_r && ((hit(e_dst, r) && (e_tnew > tuse)) ||
                         (hit(m_dst, r) && (m_tnew > tuse)));
    endfunction

    // The youngest matching producer wins; if it is not ready yet it blocks
    // older copies (they hold a stale value) and the stall covers correctness.
    function automatic logic [1:0] d_sel(input logic [ADDR_W-1:0] r,
                                         input logic [ADDR_W-1:0] e_dst,
                                         input logic [T_W-1:0]    e_tnew,
                                         input logic [ADDR_W-1:0] m_dst,
                                         input logic [T_W-1:0]    m_tnew,
                                         input logic [ADDR_W-1:0] w_dst);
        if (hit(e_dst, r)) return (e_tnew == '0) ? SEL_E : SEL_NONE;
        if (hit(m_dst, r)) return (m_tnew == '0) ? SEL_M : SEL_NONE;
        if (hit(w_dst, r)) return SEL_W;
        return SEL_NONE;
    endfunction

    function automatic logic [1:0] e_sel(input logic [ADDR_W-1:0] r,
                                         input logic [ADDR_W-1:0] m_dst,
                                         input logic [T_W-1:0]    m_tnew,
                                         input logic [ADDR_W-1:0] w_dst);
        if (hit(m_dst, r)) return (m_tnew == '0) ? SEL_M : SEL_NONE;
        if (hit(w_dst, r)) return SEL_W;
        return SEL_NONE;
    endfunction

    assign w_rs_stall = data_stall(d_rs, d_use_rs, d_tuse_rs,
                                   r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    assign w_rt_stall = data_stall(d_rt, d_use_rt, d_tuse_rt,
                                   r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    assign w_md_stall = d_is_md && e_md_stall;

    assign stall    = w_rs_stall | w_rt_stall | w_md_stall;
    assign d_fwd_rs = d_sel(d_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
    assign d_fwd_rt = d_sel(d_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
    assign e_fwd_rs = e_sel(r_e_rs, r_m_dst, r_m_tnew, r_w_dst);
    assign e_fwd_rt = e_sel(r_e_rt, r_m_dst, r_m_tnew, r_w_dst);

    // D -> E (bubble on stall), E -> M -> W always advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_e_dst  <= '0;
            r_e_tnew <= '0;
            r_m_dst  <= '0;
            r_m_tnew <= '0;
            r_w_dst  <= '0;
        end else begin
            if (stall) begin
                r_e_rs   <= '0;
                r_e_rt   <= '0;
                r_e_dst  <= '0;
                r_e_tnew <= '0;
            end else begin
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
                r_e_dst  <= d_dst;
                r_e_tnew <= d_tnew;
            end
            r_m_dst  <= r_e_dst;
            r_m_tnew <= dec_sat(r_e_tnew);
            r_w_dst  <= r_m_dst;
        end
    end

endmodule
